// File: rtl/lib_write_mod.sv
// Streams labelled feature vectors into a library RAM: one label word followed by
// n_dim feature words per vector, then a two-word header (vector count, n_dim).
module lib_write_mod #(
  parameter logic [63:0] LABEL_POS = 64'h1111111111111111,
  parameter logic [63:0] LABEL_NEG = 64'h0000000000000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  n_dim_in,
  input  logic        s_valid,
  input  logic [63:0] s_data,
  input  logic        s_label,
  input  logic        s_last,
  output logic        s_ready,
  output logic [15:0] lib_addr,
  output logic [63:0] lib_data,
  output logic        lib_wren,
  output logic        busy,
  output logic        done,
  output logic [10:0] n_vector,
  output logic        err
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned PTR_W  = 17;
  localparam int unsigned DIM_W  = 6;
  localparam int unsigned CNT_W  = 11;

  localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(2);
  localparam logic [PTR_W-1:0] ADDR_MAX  = PTR_W'(16'hFFFF);
  localparam logic [CNT_W-1:0] NVEC_MAX  = CNT_W'(2047);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LABEL = 3'd1,
    FEAT  = 3'd2,
    HDR0  = 3'd3,
    HDR1  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [DIM_W-1:0]   n_dim_q, n_dim_d;
  logic [DIM_W-1:0]   feat_q, feat_d;
  logic [CNT_W-1:0]   nvec_d;
  logic               err_d;
  logic               wren_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  data_d;
  logic               busy_d;
  logic               done_d;
  logic               fits;

  // The pointer is one bit wider than the address so it cannot wrap past 0xFFFF.
  assign fits = ((ptr_q + PTR_W'(n_dim_q)) <= ADDR_MAX) && (n_vector != NVEC_MAX);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    n_dim_d = n_dim_q;
    feat_d  = feat_q;
    nvec_d  = n_vector;
    err_d   = err;
    wren_d  = 1'b0;
    addr_d  = lib_addr;
    data_d  = lib_data;
    s_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LABEL;
          n_dim_d = n_dim_in;
          nvec_d  = '0;
          err_d   = 1'b0;
          ptr_d   = PTR_FIRST;
          feat_d  = '0;
        end
      end

      LABEL: begin
        if (!fits) begin
          err_d   = 1'b1;
          state_d = HDR0;
        end else begin
          s_ready = 1'b1;
          if (s_valid) begin
            wren_d = 1'b1;
            addr_d = ptr_q[ADDR_W-1:0];
            data_d = s_label ? LABEL_POS : LABEL_NEG;
            ptr_d  = ptr_q + PTR_W'(1);
            feat_d = '0;
            if (n_dim_q == '0) begin
              nvec_d = n_vector + CNT_W'(1);
              if (s_last) state_d = HDR0;
            end else if (s_last) begin
              err_d   = 1'b1;
              state_d = HDR0;
            end else begin
              state_d = FEAT;
            end
          end
        end
      end

      FEAT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wren_d = 1'b1;
          addr_d = ptr_q[ADDR_W-1:0];
          data_d = s_data;
          ptr_d  = ptr_q + PTR_W'(1);
          if (feat_q == DIM_W'(n_dim_q - DIM_W'(1))) begin
            nvec_d  = n_vector + CNT_W'(1);
            feat_d  = '0;
            state_d = s_last ? HDR0 : LABEL;
          end else begin
            feat_d = feat_q + DIM_W'(1);
            if (s_last) begin
              err_d   = 1'b1;
              state_d = HDR0;
            end
          end
        end
      end

      HDR0: begin
        wren_d  = 1'b1;
        addr_d  = ADDR_W'(0);
        data_d  = DATA_W'(n_vector);
        state_d = HDR1;
      end

      HDR1: begin
        wren_d  = 1'b1;
        addr_d  = ADDR_W'(1);
        data_d  = DATA_W'(n_dim_q);
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == LABEL) || (state_d == FEAT) ||
             (state_d == HDR0)  || (state_d == HDR1);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_FIRST;
      n_dim_q  <= '0;
      feat_q   <= '0;
      n_vector <= '0;
      err      <= 1'b0;
      lib_wren <= 1'b0;
      lib_addr <= '0;
      lib_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      n_dim_q  <= n_dim_d;
      feat_q   <= feat_d;
      n_vector <= nvec_d;
      err      <= err_d;
      lib_wren <= wren_d;
      lib_addr <= addr_d;
      lib_data <= data_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_lib_write_mod.sv
// Directed bench for lib_write_mod: captures every RAM write and compares against
// hand-computed library images for each scenario.
module tb_lib_write_mod;

  localparam logic [63:0] POS = 64'h1111111111111111;
  localparam logic [63:0] NEG = 64'h0000000000000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  n_dim_in;
  logic        s_valid;
  logic [63:0] s_data;
  logic        s_label;
  logic        s_last;
  logic        s_ready;
  logic [15:0] lib_addr;
  logic [63:0] lib_data;
  logic        lib_wren;
  logic        busy;
  logic        done;
  logic [10:0] n_vector;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [15:0] wa[$];
  logic [63:0] wd[$];

  lib_write_mod dut (
    .clk(clk), .rst(rst), .start(start), .n_dim_in(n_dim_in),
    .s_valid(s_valid), .s_data(s_data), .s_label(s_label), .s_last(s_last),
    .s_ready(s_ready), .lib_addr(lib_addr), .lib_data(lib_data), .lib_wren(lib_wren),
    .busy(busy), .done(done), .n_vector(n_vector), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (lib_wren) begin
      wa.push_back(lib_addr);
      wd.push_back(lib_data);
    end
  end

  task automatic send_beat(input logic lab, input logic [63:0] d, input logic last,
                           output logic ok);
    @(negedge clk);
    s_valid = 1'b1; s_label = lab; s_data = d; s_last = last;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (s_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_src(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
    end
  endtask

  task automatic do_start(input logic [5:0] nd);
    @(negedge clk);
    start = 1'b1; n_dim_in = nd;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is high, or after a bounded wait.
  task automatic wait_done(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({s_ready, lib_wren, busy, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b required 00000", {s_ready, lib_wren, busy, done, err});
    end
    checks++;
    if (lib_addr !== 16'h0 || lib_data !== 64'h0 || n_vector !== 11'd0) begin
      errors++; $display("FAIL reset_regs got addr=%h data=%h nvec=%0d required zeros", lib_addr, lib_data, n_vector);
    end
    @(negedge clk);
    rst = 1'b0;
    wa.delete(); wd.delete();
    s_valid = 1'b1; s_last = 1'b1; s_data = 64'hDEAD;
    repeat (3) @(negedge clk);
    checks++;
    if (wa.size() != 0 || s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_ignore got writes=%0d ready=%b busy=%b required 0 0 0", wa.size(), s_ready, busy);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_basic;
    logic [15:0] ea [8] = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd0, 16'd1};
    logic [63:0] ed [8] = '{POS, 64'hA, 64'hB, NEG, 64'hC, 64'hD, 64'd2, 64'd2};
    logic ok, bad, seen;
    bad = 1'b0;
    wa.delete(); wd.delete();
    do_start(6'd2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b required 1", busy); end
    send_beat(1'b1, 64'hFF, 1'b0, ok); bad |= !ok;
    send_beat(1'b0, 64'hA, 1'b0, ok); bad |= !ok;
    send_beat(1'b0, 64'hB, 1'b0, ok); bad |= !ok;
    send_beat(1'b0, 64'hEE, 1'b0, ok); bad |= !ok;
    send_beat(1'b0, 64'hC, 1'b0, ok); bad |= !ok;
    send_beat(1'b0, 64'hD, 1'b1, ok); bad |= !ok;
    idle_src(1);
    checks++;
    if (bad) begin errors++; $display("FAIL basic_accept got refused beat required all accepted"); end
    wait_done(seen);
    checks++;
    if (!seen || busy !== 1'b0) begin errors++; $display("FAIL basic_done got seen=%b busy=%b required 1 0", seen, busy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b required 0", done); end
    checks++;
    if (wa.size() != 8) begin errors++; $display("FAIL basic_wcount got %0d required 8", wa.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        errors++;
        $display("FAIL basic_write[%0d] got %h:%h required %h:%h", i,
                 (i < wa.size()) ? wa[i] : 16'hxxxx, (i < wd.size()) ? wd[i] : 64'hx, ea[i], ed[i]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_vector !== 11'd2 || err !== 1'b0) begin
      errors++; $display("FAIL basic_status got nvec=%0d err=%b required 2 0", n_vector, err);
    end
  endtask

  task automatic test_zero_dim;
    logic [15:0] ea [5] = '{16'd2, 16'd3, 16'd4, 16'd0, 16'd1};
    logic [63:0] ed [5] = '{POS, NEG, POS, 64'd3, 64'd0};
    logic ok, bad, seen;
    bad = 1'b0;
    wa.delete(); wd.delete();
    do_start(6'd0);
    send_beat(1'b1, 64'h1, 1'b0, ok); bad |= !ok;
    send_beat(1'b0, 64'h2, 1'b0, ok); bad |= !ok;
    send_beat(1'b1, 64'h3, 1'b1, ok); bad |= !ok;
    idle_src(1);
    wait_done(seen);
    @(negedge clk);
    checks++;
    if (bad || !seen) begin errors++; $display("FAIL zero_flow got bad=%b done=%b required 0 1", bad, seen); end
    checks++;
    if (wa.size() != 5) begin errors++; $display("FAIL zero_wcount got %0d required 5", wa.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        errors++;
        $display("FAIL zero_write[%0d] got %h:%h required %h:%h", i,
                 (i < wa.size()) ? wa[i] : 16'hxxxx, (i < wd.size()) ? wd[i] : 64'hx, ea[i], ed[i]);
      end
    end
    checks++;
    if (n_vector !== 11'd3 || err !== 1'b0) begin
      errors++; $display("FAIL zero_status got nvec=%0d err=%b required 3 0", n_vector, err);
    end
  endtask

  task automatic test_truncate;
    logic [15:0] ea [9] = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd0, 16'd1};
    logic [63:0] ed [9] = '{POS, 64'h11, 64'h12, 64'h13, NEG, 64'h21, 64'h22, 64'd1, 64'd3};
    logic ok, bad, seen;
    bad = 1'b0;
    wa.delete(); wd.delete();
    do_start(6'd3);
    send_beat(1'b1, 64'h0, 1'b0, ok); bad |= !ok;
    send_beat(1'b0, 64'h11, 1'b0, ok); bad |= !ok;
    send_beat(1'b0, 64'h12, 1'b0, ok); bad |= !ok;
    send_beat(1'b0, 64'h13, 1'b0, ok); bad |= !ok;
    send_beat(1'b0, 64'h0, 1'b0, ok); bad |= !ok;
    send_beat(1'b0, 64'h21, 1'b0, ok); bad |= !ok;
    send_beat(1'b0, 64'h22, 1'b1, ok); bad |= !ok;
    idle_src(1);
    wait_done(seen);
    @(negedge clk);
    checks++;
    if (bad || !seen) begin errors++; $display("FAIL trunc_flow got bad=%b done=%b required 0 1", bad, seen); end
    checks++;
    if (wa.size() != 9) begin errors++; $display("FAIL trunc_wcount got %0d required 9", wa.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        errors++;
        $display("FAIL trunc_write[%0d] got %h:%h required %h:%h", i,
                 (i < wa.size()) ? wa[i] : 16'hxxxx, (i < wd.size()) ? wd[i] : 64'hx, ea[i], ed[i]);
      end
    end
    checks++;
    if (n_vector !== 11'd1 || err !== 1'b1) begin
      errors++; $display("FAIL trunc_status got nvec=%0d err=%b required 1 1", n_vector, err);
    end
  endtask

  task automatic test_addr_overflow;
    logic ok, bad, seen;
    bad = 1'b0;
    wa.delete(); wd.delete();
    do_start(6'd63);
    for (int v = 0; v < 1023; v++) begin
      send_beat(v[0], 64'hFFFF, 1'b0, ok); bad |= !ok;
      for (int f = 0; f < 63; f++) begin
        send_beat(1'b0, 64'(v * 64 + f), 1'b0, ok); bad |= !ok;
      end
    end
    checks++;
    if (bad) begin errors++; $display("FAIL addr_ovf_accept got refused beat required all 65472 accepted"); end
    @(negedge clk);
    s_valid = 1'b1; s_label = 1'b1; s_last = 1'b0;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL addr_ovf_refuse got ready=%b required 0", s_ready); end
    idle_src(1);
    wait_done(seen);
    @(negedge clk);
    checks++;
    if (!seen) begin errors++; $display("FAIL addr_ovf_done got 0 required 1"); end
    checks++;
    if (wa.size() != 65474) begin errors++; $display("FAIL addr_ovf_wcount got %0d required 65474", wa.size()); end
    if (wa.size() == 65474) begin
      checks++;
      if (wa[65408] !== 16'd65410 || wd[65408] !== NEG || wa[65471] !== 16'd65473 || wd[65471] !== 64'(1022 * 64 + 62)) begin
        errors++; $display("FAIL addr_ovf_last got %0d:%h %0d:%h required 65410:%h 65473:%h",
                           wa[65408], wd[65408], wa[65471], wd[65471], NEG, 64'(1022 * 64 + 62));
      end
      checks++;
      if (wa[65472] !== 16'd0 || wd[65472] !== 64'd1023 || wa[65473] !== 16'd1 || wd[65473] !== 64'd63) begin
        errors++; $display("FAIL addr_ovf_hdr got %0d:%0d %0d:%0d required 0:1023 1:63",
                           wa[65472], wd[65472], wa[65473], wd[65473]);
      end
    end
    checks++;
    if (n_vector !== 11'd1023 || err !== 1'b1) begin
      errors++; $display("FAIL addr_ovf_status got nvec=%0d err=%b required 1023 1", n_vector, err);
    end
  endtask

  task automatic test_count_overflow;
    logic ok, bad, seen;
    bad = 1'b0;
    wa.delete(); wd.delete();
    do_start(6'd0);
    for (int v = 0; v < 2047; v++) begin
      send_beat(1'b1, 64'h0, 1'b0, ok); bad |= !ok;
    end
    @(negedge clk);
    checks++;
    if (bad || s_ready !== 1'b0) begin errors++; $display("FAIL cnt_ovf_refuse got bad=%b ready=%b required 0 0", bad, s_ready); end
    idle_src(1);
    wait_done(seen);
    @(negedge clk);
    checks++;
    if (!seen || wa.size() != 2049) begin errors++; $display("FAIL cnt_ovf_wcount got done=%b writes=%0d required 1 2049", seen, wa.size()); end
    if (wa.size() == 2049) begin
      checks++;
      if (wa[2046] !== 16'd2048 || wa[2047] !== 16'd0 || wd[2047] !== 64'd2047 || wa[2048] !== 16'd1 || wd[2048] !== 64'd0) begin
        errors++; $display("FAIL cnt_ovf_hdr got last=%0d %0d:%0d %0d:%0d required 2048 0:2047 1:0",
                           wa[2046], wa[2047], wd[2047], wa[2048], wd[2048]);
      end
    end
    checks++;
    if (n_vector !== 11'd2047 || err !== 1'b1) begin
      errors++; $display("FAIL cnt_ovf_status got nvec=%0d err=%b required 2047 1", n_vector, err);
    end
  endtask

  task automatic test_gaps_restart_reset;
    logic [15:0] ea [5] = '{16'd2, 16'd3, 16'd4, 16'd0, 16'd1};
    logic [63:0] ed [5] = '{POS, 64'hA, 64'hB, 64'd1, 64'd2};
    logic [15:0] fa [4] = '{16'd2, 16'd3, 16'd0, 16'd1};
    logic [63:0] fd [4] = '{POS, 64'h55, 64'd1, 64'd1};
    logic ok, bad, seen;
    bad = 1'b0;
    wa.delete(); wd.delete();
    do_start(6'd2);
    send_beat(1'b1, 64'h0, 1'b0, ok); bad |= !ok;
    idle_src(2);
    do_start(6'd5);
    idle_src(1);
    send_beat(1'b0, 64'hA, 1'b0, ok); bad |= !ok;
    idle_src(3);
    send_beat(1'b0, 64'hB, 1'b1, ok); bad |= !ok;
    idle_src(1);
    wait_done(seen);
    @(negedge clk);
    checks++;
    if (bad || !seen) begin errors++; $display("FAIL gap_flow got bad=%b done=%b required 0 1", bad, seen); end
    checks++;
    if (wa.size() != 5) begin errors++; $display("FAIL gap_wcount got %0d required 5", wa.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        errors++;
        $display("FAIL gap_write[%0d] got %h:%h required %h:%h", i,
                 (i < wa.size()) ? wa[i] : 16'hxxxx, (i < wd.size()) ? wd[i] : 64'hx, ea[i], ed[i]);
      end
    end

    // Abandon a build mid-vector, then rebuild from scratch.
    wa.delete(); wd.delete();
    do_start(6'd1);
    send_beat(1'b0, 64'h0, 1'b0, ok);
    idle_src(2);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({s_ready, lib_wren, busy, done, err} !== 5'b0 || lib_addr !== 16'h0 || lib_data !== 64'h0 || n_vector !== 11'd0) begin
      errors++; $display("FAIL midreset_outputs got flags=%b addr=%h data=%h nvec=%0d required all zero",
                         {s_ready, lib_wren, busy, done, err}, lib_addr, lib_data, n_vector);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wa.size() != 1 || (wa.size() == 1 && (wa[0] !== 16'd2 || wd[0] !== NEG))) begin
      errors++; $display("FAIL midreset_writes got count=%0d required 1 (2:NEG)", wa.size());
    end
    wa.delete(); wd.delete();
    bad = 1'b0;
    do_start(6'd1);
    send_beat(1'b1, 64'h0, 1'b0, ok); bad |= !ok;
    send_beat(1'b0, 64'h55, 1'b1, ok); bad |= !ok;
    idle_src(1);
    wait_done(seen);
    @(negedge clk);
    checks++;
    if (bad || !seen || wa.size() != 4) begin
      errors++; $display("FAIL rebuild_flow got bad=%b done=%b writes=%0d required 0 1 4", bad, seen, wa.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== fa[i] || wd[i] !== fd[i]) begin
        errors++;
        $display("FAIL rebuild_write[%0d] got %h:%h required %h:%h", i,
                 (i < wa.size()) ? wa[i] : 16'hxxxx, (i < wd.size()) ? wd[i] : 64'hx, fa[i], fd[i]);
      end
    end
    checks++;
    if (n_vector !== 11'd1 || err !== 1'b0) begin
      errors++; $display("FAIL rebuild_status got nvec=%0d err=%b required 1 0", n_vector, err);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_dim_in = '0;
    s_valid = 1'b0; s_data = '0; s_label = 1'b0; s_last = 1'b0;
    #2;
    test_reset;
    test_basic;
    test_zero_dim;
    test_truncate;
    test_gaps_restart_reset;
    test_count_overflow;
    test_addr_overflow;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
